// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_pkg
// Purpose  : Shared types and constants for the USB transmit bitstream path.
//            Packet class codes, PID nibbles, encoder state encoding and a
//            PID/packet-class consistency helper.
// Revision : 1.0  initial release
// ============================================================================
package usb_pkg;

  // Packet class requested by protocolFSM
  typedef enum logic [1:0] {
    PKT_NONE   = 2'b00,
    PKT_TOKEN  = 2'b01,
    PKT_HSHAKE = 2'b10,
    PKT_DATA   = 2'b11
  } pkt_t;

  // Encoder state encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PID   = 3'd1,
    ST_TOKEN = 3'd2,
    ST_DATA  = 3'd3,
    ST_DONE  = 3'd4
  } enc_state_t;

  // PID nibbles (transmitted LSB first, followed by their complement)
  localparam logic [3:0] c_PID_OUT   = 4'b0001;
  localparam logic [3:0] c_PID_IN    = 4'b1001;
  localparam logic [3:0] c_PID_SETUP = 4'b1101;
  localparam logic [3:0] c_PID_DATA0 = 4'b0011;
  localparam logic [3:0] c_PID_DATA1 = 4'b1011;
  localparam logic [3:0] c_PID_ACK   = 4'b0010;
  localparam logic [3:0] c_PID_NAK   = 4'b1010;
  localparam logic [3:0] c_PID_STALL = 4'b1110;

  // True when the PID's class bits [1:0] agree with the packet class and the
  // PID is not the reserved value 0000.
  function automatic logic pid_class_ok(input logic [3:0] pid, input pkt_t kind);
    logic ok;
    ok = 1'b0;
    case (kind)
      PKT_TOKEN:  ok = (pid[1:0] == 2'b01);
      PKT_HSHAKE: ok = (pid[1:0] == 2'b10);
      PKT_DATA:   ok = (pid[1:0] == 2'b11);
      default:    ok = 1'b0;
    endcase
    if (pid == 4'b0000) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tx_shift_reg
// Purpose  : 8-bit load/shift register with 3-bit bit counter and empty flag.
//            bit_out is always the bit currently on the line (sr[0]).
// Ports    : clk, rst (async, active high)
//            clr        - synchronous clear to the empty state
//            load       - load load_data, bit counter to 0 (wins over shift)
//            shift      - advance one bit; after bit 7 the register is empty
//            stall      - hold contents and counter
//            bit_out    - current bit, bit_cnt - its index
//            last_bit   - the 8th bit is on the line, empty - nothing loaded
// Revision : 1.0  initial release
// ============================================================================
module tx_shift_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  input  logic       stall,
  output logic       bit_out,
  output logic [2:0] bit_cnt,
  output logic       last_bit,
  output logic       empty
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       empty_q, empty_d;

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    empty_d = empty_q;
    if (clr) begin
      sr_d    = 8'h00;
      cnt_d   = 3'd0;
      empty_d = 1'b1;
    end else if (load) begin
      sr_d    = load_data;
      cnt_d   = 3'd0;
      empty_d = 1'b0;
    end else if (shift && !stall && !empty_q) begin
      if (cnt_q == 3'd7) begin
        sr_d    = 8'h00;
        cnt_d   = 3'd0;
        empty_d = 1'b1;
      end else begin
        sr_d  = {1'b0, sr_q[7:1]};
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= 8'h00;
      cnt_q   <= 3'd0;
      empty_q <= 1'b1;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
    end
  end

  assign bit_out  = sr_q[0];
  assign bit_cnt  = cnt_q;
  assign last_bit = (cnt_q == 3'd7) && !empty_q;
  assign empty    = empty_q;

endmodule
`default_nettype wire

// File: rtl/bs_encoder.sv
`default_nettype none
// ============================================================================
// Module   : bs_encoder
// Purpose  : Serialises one USB packet (PID, then token fields or payload)
//            LSB first into a 1-bit stream for tx_crc / bitStuffer, framing
//            the CRC-covered region with start_crc / end_crc pulses.
// Ports    : clk, rst (async, active high), abort (sync, highest priority)
//            start_encode, pkt_type, pid, token_fields, zlp  - packet request
//            data_byte, data_valid, data_last, data_ready    - payload handshake
//            stall                                           - freeze stream
//            s_out, s_valid, start_crc, end_crc              - serial stream
//            bs_encoder_busy, encode_done, tx_error          - status
// Options  : TX_PID_CHECK_EN - reject reserved / class-mismatched PIDs in IDLE
// Revision : 1.0  initial release
// ============================================================================
module bs_encoder #(
  parameter int MAX_PAYLOAD = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start_encode,
  input  logic [1:0]  pkt_type,
  input  logic [3:0]  pid,
  input  logic [10:0] token_fields,
  input  logic        zlp,
  input  logic [7:0]  data_byte,
  input  logic        data_valid,
  input  logic        data_last,
  output logic        data_ready,
  input  logic        stall,
  output logic        s_out,
  output logic        s_valid,
  output logic        start_crc,
  output logic        end_crc,
  output logic        bs_encoder_busy,
  output logic        encode_done,
  output logic        tx_error
);
  import usb_pkg::*;

  localparam int             BCW       = $clog2(MAX_PAYLOAD + 1);
  localparam logic [BCW-1:0] c_MAX_CNT = BCW'(MAX_PAYLOAD);

  enc_state_t     state_q, state_d;
  pkt_t           pkt_q, pkt_d;
  logic           zlp_q, zlp_d;
  logic [10:0]    tok_q, tok_d;
  logic [3:0]     tok_cnt_q, tok_cnt_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic           hold_last_q, hold_last_d;
  logic           last_seen_q, last_seen_d;
  logic           cur_last_q, cur_last_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic           s_valid_q, s_valid_d;
  logic           start_crc_q, start_crc_d;
  logic           end_crc_q, end_crc_d;
  logic           encode_done_q, encode_done_d;
  logic           tx_error_q, tx_error_d;

  logic       sr_clr, sr_load, sr_shift;
  logic [7:0] sr_load_data;
  logic       sr_bit, sr_last_bit, sr_empty;
  logic [2:0] sr_cnt;

  logic       w_pid_ok;
  logic       w_xfer, w_overrun, w_next_avail, w_next_last, w_need_byte;
  logic [7:0] w_next_byte;

  tx_shift_reg u_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (sr_clr),
    .load      (sr_load),
    .load_data (sr_load_data),
    .shift     (sr_shift),
    .stall     (stall),
    .bit_out   (sr_bit),
    .bit_cnt   (sr_cnt),
    .last_bit  (sr_last_bit),
    .empty     (sr_empty)
  );

`ifdef TX_PID_CHECK_EN
  assign w_pid_ok = pid_class_ok(pid, pkt_t'(pkt_type));
`else
  assign w_pid_ok = 1'b1;
`endif

  // Payload is only requested for DATA packets; a token or handshake PID
  // phase never pulls bytes from protocolFSM.
  assign data_ready = ((state_q == ST_PID) || (state_q == ST_DATA)) &&
                      (pkt_q == PKT_DATA) && !zlp_q && !hold_full_q && !last_seen_q;
  assign w_xfer     = data_valid && data_ready;
  assign w_overrun  = w_xfer && (byte_cnt_q == c_MAX_CNT);

  // A byte arriving in the very cycle the shifter needs one bypasses the
  // holding register so it does not count as an underrun.
  assign w_next_avail = hold_full_q || w_xfer;
  assign w_next_byte  = hold_full_q ? hold_q      : data_byte;
  assign w_next_last  = hold_full_q ? hold_last_q : data_last;

  always_comb begin
    state_d       = state_q;
    pkt_d         = pkt_q;
    zlp_d         = zlp_q;
    tok_d         = tok_q;
    tok_cnt_d     = tok_cnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    hold_last_d   = hold_last_q;
    last_seen_d   = last_seen_q;
    cur_last_d    = cur_last_q;
    byte_cnt_d    = byte_cnt_q;
    s_valid_d     = s_valid_q;
    start_crc_d   = 1'b0;
    end_crc_d     = 1'b0;
    encode_done_d = 1'b0;
    tx_error_d    = 1'b0;
    sr_clr        = 1'b0;
    sr_load       = 1'b0;
    sr_load_data  = 8'h00;
    sr_shift      = 1'b0;
    w_need_byte   = 1'b0;

    // Holding register accepts even while stalled
    if (w_xfer) begin
      hold_d      = data_byte;
      hold_full_d = 1'b1;
      hold_last_d = data_last;
      byte_cnt_d  = byte_cnt_q + BCW'(1);
      if (data_last) begin
        last_seen_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        s_valid_d = 1'b0;
        if (start_encode && (pkt_type != PKT_NONE)) begin
          if (w_pid_ok) begin
            state_d      = ST_PID;
            pkt_d        = pkt_t'(pkt_type);
            zlp_d        = zlp;
            tok_d        = token_fields;
            tok_cnt_d    = 4'd0;
            hold_full_d  = 1'b0;
            hold_last_d  = 1'b0;
            last_seen_d  = 1'b0;
            cur_last_d   = 1'b0;
            byte_cnt_d   = '0;
            sr_load      = 1'b1;
            sr_load_data = {~pid, pid};
            s_valid_d    = 1'b1;
          end else begin
            tx_error_d = 1'b1;
          end
        end
      end

      ST_PID: begin
        if (!stall) begin
          sr_shift = !sr_empty;
          if (sr_last_bit) begin
            case (pkt_q)
              PKT_TOKEN: begin
                state_d     = ST_TOKEN;
                start_crc_d = 1'b1;
              end
              PKT_DATA: begin
                if (zlp_q) begin
                  // Empty CRC region: both pulses with no data bit
                  state_d       = ST_DONE;
                  s_valid_d     = 1'b0;
                  start_crc_d   = 1'b1;
                  end_crc_d     = 1'b1;
                  encode_done_d = 1'b1;
                end else begin
                  start_crc_d = 1'b1;
                  w_need_byte = 1'b1;
                end
              end
              PKT_HSHAKE: begin
                state_d       = ST_DONE;
                s_valid_d     = 1'b0;
                encode_done_d = 1'b1;
              end
              default: begin
                state_d   = ST_IDLE;
                s_valid_d = 1'b0;
              end
            endcase
          end
        end
      end

      ST_TOKEN: begin
        if (!stall) begin
          if (tok_cnt_q == 4'd10) begin
            state_d       = ST_DONE;
            s_valid_d     = 1'b0;
            encode_done_d = 1'b1;
          end else begin
            tok_d     = {1'b0, tok_q[10:1]};
            tok_cnt_d = tok_cnt_q + 4'd1;
            end_crc_d = (tok_cnt_q == 4'd9);
          end
        end
      end

      ST_DATA: begin
        if (!stall) begin
          sr_shift  = !sr_empty;
          end_crc_d = cur_last_q && (sr_cnt == 3'd6);
          if (sr_last_bit) begin
            if (cur_last_q) begin
              state_d       = ST_DONE;
              s_valid_d     = 1'b0;
              encode_done_d = 1'b1;
            end else begin
              w_need_byte = 1'b1;
            end
          end
        end
      end

      ST_DONE: begin
        state_d   = ST_IDLE;
        s_valid_d = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        s_valid_d = 1'b0;
      end
    endcase

    // Reload the shifter at a byte boundary, or flag underrun
    if (w_need_byte) begin
      if (w_next_avail) begin
        state_d      = ST_DATA;
        sr_load      = 1'b1;
        sr_load_data = w_next_byte;
        cur_last_d   = w_next_last;
        hold_full_d  = 1'b0;
      end else begin
        state_d     = ST_IDLE;
        s_valid_d   = 1'b0;
        start_crc_d = 1'b0;
        tx_error_d  = 1'b1;
      end
    end

    if (w_overrun) begin
      state_d       = ST_IDLE;
      s_valid_d     = 1'b0;
      start_crc_d   = 1'b0;
      end_crc_d     = 1'b0;
      encode_done_d = 1'b0;
      tx_error_d    = 1'b1;
      hold_full_d   = 1'b0;
      sr_load       = 1'b0;
      sr_clr        = 1'b1;
    end

    if (abort) begin
      state_d       = ST_IDLE;
      pkt_d         = PKT_NONE;
      zlp_d         = 1'b0;
      tok_d         = 11'h000;
      tok_cnt_d     = 4'd0;
      hold_d        = 8'h00;
      hold_full_d   = 1'b0;
      hold_last_d   = 1'b0;
      last_seen_d   = 1'b0;
      cur_last_d    = 1'b0;
      byte_cnt_d    = '0;
      s_valid_d     = 1'b0;
      start_crc_d   = 1'b0;
      end_crc_d     = 1'b0;
      encode_done_d = 1'b0;
      tx_error_d    = 1'b0;
      sr_load       = 1'b0;
      sr_clr        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pkt_q         <= PKT_NONE;
      zlp_q         <= 1'b0;
      tok_q         <= 11'h000;
      tok_cnt_q     <= 4'd0;
      hold_q        <= 8'h00;
      hold_full_q   <= 1'b0;
      hold_last_q   <= 1'b0;
      last_seen_q   <= 1'b0;
      cur_last_q    <= 1'b0;
      byte_cnt_q    <= '0;
      s_valid_q     <= 1'b0;
      start_crc_q   <= 1'b0;
      end_crc_q     <= 1'b0;
      encode_done_q <= 1'b0;
      tx_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pkt_q         <= pkt_d;
      zlp_q         <= zlp_d;
      tok_q         <= tok_d;
      tok_cnt_q     <= tok_cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      hold_last_q   <= hold_last_d;
      last_seen_q   <= last_seen_d;
      cur_last_q    <= cur_last_d;
      byte_cnt_q    <= byte_cnt_d;
      s_valid_q     <= s_valid_d;
      start_crc_q   <= start_crc_d;
      end_crc_q     <= end_crc_d;
      encode_done_q <= encode_done_d;
      tx_error_q    <= tx_error_d;
    end
  end

  // The line bit comes straight from the active register; gated by s_valid
  // so idle and DONE cycles drive 0.
  assign s_out           = s_valid_q & ((state_q == ST_TOKEN) ? tok_q[0] : sr_bit);
  assign s_valid         = s_valid_q;
  assign start_crc       = start_crc_q;
  assign end_crc         = end_crc_q;
  assign encode_done     = encode_done_q;
  assign tx_error        = tx_error_q;
  assign bs_encoder_busy = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bs_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bs_encoder
// Purpose  : Directed self-checking bench for bs_encoder. Each packet's
//            serial stream is collected LSB first and compared against
//            hand-computed constants (PID byte, token fields, payload).
// Revision : 1.0  initial release
// ============================================================================
module tb_bs_encoder;

  logic        clk = 1'b0;
  logic        rst, abort, start_encode, zlp;
  logic [1:0]  pkt_type;
  logic [3:0]  pid;
  logic [10:0] token_fields;
  logic [7:0]  data_byte;
  logic        data_valid, data_last, data_ready, stall;
  logic        s_out, s_valid, start_crc, end_crc;
  logic        bs_encoder_busy, encode_done, tx_error;

  always #5 clk = ~clk;

  bs_encoder #(.MAX_PAYLOAD(1023)) dut (
    .clk             (clk),
    .rst             (rst),
    .abort           (abort),
    .start_encode    (start_encode),
    .pkt_type        (pkt_type),
    .pid             (pid),
    .token_fields    (token_fields),
    .zlp             (zlp),
    .data_byte       (data_byte),
    .data_valid      (data_valid),
    .data_last       (data_last),
    .data_ready      (data_ready),
    .stall           (stall),
    .s_out           (s_out),
    .s_valid         (s_valid),
    .start_crc       (start_crc),
    .end_crc         (end_crc),
    .bs_encoder_busy (bs_encoder_busy),
    .encode_done     (encode_done),
    .tx_error        (tx_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Per-packet observation record
  logic [63:0] m_bits;
  int          m_n, m_vcyc, m_held, m_sc_cnt, m_ec_cnt, m_sc_idx, m_ec_idx, m_end_cyc;
  bit          m_sv_at_ec, m_done, m_err, m_ready, m_busy_end;
  logic [8:0]  pay_q[$];   // {last, byte}

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_pkt(input logic [1:0] t, input logic [3:0] p,
                           input logic [10:0] tf, input logic z);
    pkt_type     = t;
    pid          = p;
    token_fields = tf;
    zlp          = z;
    start_encode = 1'b1;
    tick();
    start_encode = 1'b0;
    pkt_type     = 2'b00;
  endtask

  // Collects the stream until encode_done or tx_error. Feeds pay_q when the
  // encoder is ready and holds stall for stall_len cycles once bit stall_at
  // first appears; bits repeated by a stall are counted in m_held only.
  task automatic run_pkt(input string tag, input int budget, input int stall_at, input int stall_len);
    int stall_left;
    bit stall_prev;
    bit stall_armed;
    stall_left  = 0;
    stall_prev  = 1'b0;
    stall_armed = (stall_at >= 0);
    m_bits = '0; m_n = 0; m_vcyc = 0; m_held = 0;
    m_sc_cnt = 0; m_ec_cnt = 0; m_sc_idx = -1; m_ec_idx = -1; m_end_cyc = -1;
    m_sv_at_ec = 1'b0; m_done = 1'b0; m_err = 1'b0; m_ready = 1'b0; m_busy_end = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (s_valid) begin
        m_vcyc++;
        if (stall_prev) begin
          m_held++;
        end else begin
          m_bits[m_n] = s_out;
          m_n++;
        end
      end
      if (data_ready) m_ready = 1'b1;
      if (start_crc) begin
        m_sc_cnt++;
        m_sc_idx = s_valid ? m_n - 1 : m_n;
      end
      if (end_crc) begin
        m_ec_cnt++;
        m_ec_idx   = s_valid ? m_n - 1 : m_n;
        m_sv_at_ec = s_valid;
      end
      if (encode_done || tx_error) begin
        m_done     = encode_done;
        m_err      = tx_error;
        m_busy_end = bs_encoder_busy;
        m_end_cyc  = c + 1;
        break;
      end
      if (stall_armed && s_valid && (m_n - 1 == stall_at)) begin
        stall_left  = stall_len;
        stall_armed = 1'b0;
      end
      stall = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      stall_prev = stall;
      if (data_ready && pay_q.size() > 0) begin
        {data_last, data_byte} = pay_q.pop_front();
        data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
        data_last  = 1'b0;
        data_byte  = 8'h00;
      end
      tick();
    end
    stall      = 1'b0;
    data_valid = 1'b0;
    data_last  = 1'b0;
    check_val({tag, "_term"}, {63'd0, m_done | m_err}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dn, er;
    rst = 1'b1; abort = 1'b0; start_encode = 1'b0; pkt_type = 2'b00; pid = 4'h0;
    token_fields = 11'h000; zlp = 1'b0; data_byte = 8'h00; data_valid = 1'b0;
    data_last = 1'b0; stall = 1'b0;
    tick(); tick();
    check_val("reset_outs",
              {56'd0, s_out, s_valid, start_crc, end_crc, bs_encoder_busy,
               encode_done, tx_error, data_ready}, 64'd0);
    rst = 1'b0;
    tick();

    // ACK: byte D2h, no CRC pulses, done on cycle 9
    start_pkt(2'b10, 4'b0010, 11'h000, 1'b0);
    run_pkt("ack", 30, -1, 0);
    check_val("ack_bits",  m_bits, 64'hD2);
    check_val("ack_nbits", m_n, 8);
    check_val("ack_done",  {m_done, m_err}, 2'b10);
    check_val("ack_cyc",   m_end_cyc, 9);
    check_val("ack_crc",   m_sc_cnt + m_ec_cnt, 0);
    check_val("ack_busy_in_done", m_busy_end, 1);
    tick();
    check_val("ack_idle", bs_encoder_busy, 0);

    // OUT token addr 5 endp 1: E1h then 085h (11 bits)
    start_pkt(2'b01, 4'b0001, {4'd1, 7'd5}, 1'b0);
    run_pkt("tok", 40, -1, 0);
    check_val("tok_bits",  m_bits, 64'h085E1);
    check_val("tok_nbits", m_n, 19);
    check_val("tok_sc",    {m_sc_cnt, m_sc_idx}, {32'd1, 32'd8});
    check_val("tok_ec",    {m_ec_cnt, m_ec_idx}, {32'd1, 32'd18});
    check_val("tok_done",  {m_done, m_err}, 2'b10);
    tick();

    // DATA0 A5h, 3Ch(last) with bit 12 stalled 2 cycles
    pay_q = {9'h0A5, 9'h13C};
    start_pkt(2'b11, 4'b0011, 11'h000, 1'b0);
    run_pkt("d0", 60, 12, 2);
    check_val("d0_bits",  m_bits, 64'h3CA5C3);
    check_val("d0_nbits", m_n, 24);
    check_val("d0_vcyc",  m_vcyc, 26);
    check_val("d0_held",  m_held, 2);
    check_val("d0_sc",    {m_sc_cnt, m_sc_idx}, {32'd1, 32'd8});
    check_val("d0_ec",    {m_ec_cnt, m_ec_idx}, {32'd1, 32'd23});
    check_val("d0_done",  {m_done, m_err}, 2'b10);
    tick();

    // DATA1 zero-length: 4Bh then both CRC pulses with s_valid low
    start_pkt(2'b11, 4'b1011, 11'h000, 1'b1);
    run_pkt("zlp", 30, -1, 0);
    check_val("zlp_bits",  m_bits, 64'h4B);
    check_val("zlp_nbits", m_n, 8);
    check_val("zlp_crc",   {m_sc_cnt, m_ec_cnt, m_sc_idx, m_ec_idx},
              {32'd1, 32'd1, 32'd8, 32'd8});
    check_val("zlp_sv",    m_sv_at_ec, 0);
    check_val("zlp_ready", m_ready, 0);
    check_val("zlp_done",  {m_done, m_err}, 2'b10);
    tick();

    // Underrun: only A5h supplied, not marked last
    pay_q = {9'h0A5};
    start_pkt(2'b11, 4'b0011, 11'h000, 1'b0);
    run_pkt("ur", 40, -1, 0);
    check_val("ur_err",   {m_done, m_err}, 2'b01);
    check_val("ur_bits",  m_bits, 64'hA5C3);
    check_val("ur_nbits", m_n, 16);
    check_val("ur_ec",    m_ec_cnt, 0);
    check_val("ur_busy",  m_busy_end, 0);
    tick();
    check_val("ur_err_pulse", tx_error, 0);

    // Abort in the middle of the PID
    start_pkt(2'b11, 4'b0011, 11'h000, 1'b0);
    tick(); tick();
    check_val("ab_busy_pre", bs_encoder_busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("ab_idle", {bs_encoder_busy, s_valid}, 2'b00);
    dn = 0; er = 0;
    for (int i = 0; i < 12; i++) begin
      if (encode_done) dn++;
      if (tx_error) er++;
      tick();
    end
    check_val("ab_no_done", {dn, er}, 64'd0);

    // NONE request is ignored
    start_pkt(2'b00, 4'b0010, 11'h000, 1'b0);
    check_val("none_ign", {bs_encoder_busy, s_valid, tx_error}, 3'b000);
    tick();

    // Handshake request carrying a token-class PID
    start_pkt(2'b10, 4'b0001, 11'h000, 1'b0);
`ifdef TX_PID_CHECK_EN
    check_val("pidchk_err", {tx_error, s_valid, bs_encoder_busy}, 3'b100);
    tick();
    check_val("pidchk_pulse", {tx_error, s_valid}, 2'b00);
`else
    run_pkt("pidnc", 30, -1, 0);
    check_val("pidnc_bits", m_bits, 64'hE1);
    check_val("pidnc_done", {m_done, m_err}, 2'b10);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bs_encoder.md
Name: bs_encoder

Overview:
- Transmit-side counterpart of the receive bitstream decoder: serialises one USB packet (PID, then token fields or data payload) into a 1-bit stream, LSB first.
- The stream feeds the transmit CRC generator and bit stuffer.
- Sits between protocolFSM, which supplies the packet request and payload bytes, and the tx_crc / bitStuffer chain.
- Frames the CRC-covered region with start_crc/end_crc pulses.

Parameters:
- MAX_PAYLOAD, 1023: maximum payload bytes per DATA packet. Byte counter width is $clog2(MAX_PAYLOAD+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- abort  in  1  synchronous abort; returns the block to IDLE
- start_encode  in  1  packet request, sampled in IDLE
- pkt_type  in  2  NONE=00, TOKEN=01, HSHAKE=10, DATA=11
- pid  in  4  PID nibble
- token_fields  in  11  {endp[3:0], addr[6:0]}; addr is sent first
- zlp  in  1  DATA packet with zero payload
- data_byte  in  8  payload byte
- data_valid  in  1  payload byte valid
- data_last  in  1  marks the final payload byte
- data_ready  out  1  encoder can accept a byte
- stall  in  1  bitStuffer is inserting a stuff bit; hold all state
- s_out  out  1  serial bit
- s_valid  out  1  s_out carries a packet bit
- start_crc  out  1  pulse with the first CRC-covered bit
- end_crc  out  1  pulse with the last CRC-covered bit
- bs_encoder_busy  out  1  packet in progress
- encode_done  out  1  one-cycle pulse after the last bit
- tx_error  out  1  one-cycle pulse on underrun, overrun or invalid request

Behaviour:
- Reset: all outputs 0; state IDLE; shifter, holding register and counters cleared.
- Reset is asynchronous. abort (synchronous) has the same effect, takes priority over every other input, and produces no encode_done.
- States: IDLE, PID, TOKEN, DATA, DONE.
- IDLE:
  - start_encode with pkt_type!=NONE latches pid, pkt_type, token_fields and zlp, loads shifter with {~pid,pid}, goes to PID.
  - start_encode with pkt_type==NONE is ignored.
- PID: 8 bits; first bit appears on s_out the cycle after start_encode is accepted; s_valid=1 on each bit.
- After the 8th PID bit:
  - HSHAKE -> DONE; no CRC pulses.
  - TOKEN -> TOKEN.
  - DATA with zlp -> DONE, with start_crc and end_crc both pulsed in that transition cycle while s_valid=0.
  - DATA otherwise -> DATA.
- TOKEN: 11 bits, LSB first; start_crc on bit 0, end_crc on bit 10; then DONE.
- DATA:
  - Holding register is one byte deep.
  - data_ready = (state in PID or DATA) && !zlp_latched && holding empty && !last_seen.
  - Transfer occurs on data_valid && data_ready.
  - Shifter reloads from holding when its 8th bit goes out.
  - start_crc on the first payload bit.
  - end_crc on the 8th bit of the byte tagged data_last; then DONE.
- Underrun: shifter empties in DATA while holding is empty and last_seen=0 -> tx_error pulse, state IDLE, no end_crc.
- Overrun: byte count would exceed MAX_PAYLOAD -> tx_error, state IDLE.
- stall=1: s_out, s_valid, shift position, counters and state frozen; CRC pulses are not repeated; a data transfer in a stalled cycle is still accepted.
- DONE: encode_done=1 for one cycle, then IDLE.
- bs_encoder_busy=1 in every state except IDLE.
- start_encode outside IDLE is ignored.

Optional Feature:
- Macro TX_PID_CHECK_EN.
- Defined: in IDLE, a request whose pid is reserved (4'b0000) or whose pid class mismatches pkt_type raises tx_error for one cycle. The packet is not sent and the block stays in IDLE. Valid classes: token pid[1:0]=01, handshake pid[1:0]=10, data pid[1:0]=11.
- Undefined: any pid is transmitted unchecked.

Decomposition:
- usb_pkg holds pkt_t enum (NONE, TOKEN, HSHAKE, DATA with the codes above), PID constants (OUT, IN, SETUP, DATA0, DATA1, ACK, NAK, STALL) and state enum enc_state_t.
- One sub-module, tx_shift_reg: 8-bit load/shift register, 3-bit bit counter, empty flag, stall hold.

Test Plan:
- ACK (pkt_type=10, pid=0010): s_out 0,1,0,0,1,0,1,1 on cycles 1-8; encode_done on cycle 9; start_crc and end_crc never asserted.
- OUT token (pid=0001, addr=05, endp=1): PID byte E1h, then 1,0,1,0,0,0,0,1,0,0,0; start_crc with stream bit 8, end_crc with bit 18.
- DATA0 payload A5h,3Ch (last on 3Ch), stall held on bit 12 for 2 cycles: 24 valid bits; bit 12 held 3 cycles; end_crc on the final bit of 3Ch.
- DATA1 with zlp=1: 8 PID bits, then start_crc and end_crc together with s_valid=0; data_ready never asserted.
- DATA: second byte withheld past the first byte's last bit -> tx_error pulse, IDLE, no end_crc. Separate run: abort mid-PID -> IDLE next cycle, no encode_done.
- With TX_PID_CHECK_EN: pkt_type=HSHAKE, pid=0001 -> tx_error, s_valid stays 0.
